// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC pair register, inst RAM data capture and handoff to decode
//
// Purpose:
//   Holds the PC pair issued by pre-fetch while the synchronous instruction RAM
//   returns its data. RAM data is live only in the cycle right after a load; if
//   decode stalls in that cycle the data is captured into a local buffer so the
//   fetch packet stays stable for any stall length. Branch and exception flushes
//   kill the current packet combinationally and force the new target PC in.
//
// Ports:
//   clk                  in   1        clock, rising edge
//   rst_n                in   1        asynchronous active-low reset
//   pre_to_now_valid_i   in   1        pre-fetch offers a PC pair
//   pre_to_ibus          in   2*PC_W   {pc2, pc1} from pre-fetch
//   now_allowin_o        out  1        this stage accepts a new PC pair
//   inst_rdata_i         in   64       {inst2, inst1} from inst RAM
//   next_allowin_i       in   1        decode accepts this cycle
//   now_to_next_valid_o  out  1        fetch packet valid toward decode
//   branch_flush_i       in   1        taken branch, current content wrong-path
//   excep_flush_i        in   1        exception entry / ertn, content killed
//   to_preif_obus        out  PC_W     current pc1 fed back to pre-fetch
//   to_id_obus           out  2*PC_W+65 {adef, pc2, inst2, pc1, inst1}

module if_stage #(
  parameter int unsigned       PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = 32'h1BFF_FFFC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pre_to_now_valid_i,
  input  logic [2*PC_W-1:0]    pre_to_ibus,
  output logic                 now_allowin_o,
  input  logic [63:0]          inst_rdata_i,
  input  logic                 next_allowin_i,
  output logic                 now_to_next_valid_o,
  input  logic                 branch_flush_i,
  input  logic                 excep_flush_i,
  output logic [PC_W-1:0]      to_preif_obus,
  output logic [2*PC_W+64:0]   to_id_obus
);

  // pc2 of the reset pair; the upstream +4 turns RESET_PC into the first fetch address.
  localparam logic [PC_W-1:0] RESET_PC2 = RESET_PC + PC_W'(4);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              valid_q,     valid_d;
  logic              first_q,     first_d;      // RAM data for this pair is live this cycle
  logic              buf_valid_q, buf_valid_d;
  logic [63:0]       buf_q,       buf_d;
  logic [PC_W-1:0]   pc1_q,       pc1_d;
  logic [PC_W-1:0]   pc2_q,       pc2_d;

  // ---------------------------------------------------------------------------
  // Control terms
  // ---------------------------------------------------------------------------
  logic              flush;
  logic              load;
  logic              handoff;
  logic              capture;
  logic [63:0]       inst_pair;
  logic              adef;

  // Both flush sources have the same local effect; their relative priority is
  // settled upstream in the target PC presented on pre_to_ibus.
  assign flush   = branch_flush_i | excep_flush_i;

  // ready_go is always 1, so the stage frees up whenever decode takes the
  // packet or the packet is being killed.
  assign load    = !valid_q | next_allowin_i | flush;

  assign handoff = now_to_next_valid_o & next_allowin_i;

  // Decode stalled during the only cycle the RAM output belongs to us: keep a copy.
  assign capture = first_q & valid_q & !next_allowin_i & !flush;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d     = valid_q;
    first_d     = 1'b0;
    pc1_d       = pc1_q;
    pc2_d       = pc2_q;
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;

    if (load) begin
      valid_d = pre_to_now_valid_i;
      first_d = pre_to_now_valid_i;
      pc1_d   = pre_to_ibus[PC_W-1:0];
      pc2_d   = pre_to_ibus[2*PC_W-1:PC_W];
    end

    // Any load, handoff or flush retires the buffered packet; capture can only
    // happen while holding, so the two branches never compete.
    if (load | handoff | flush) begin
      buf_valid_d = 1'b0;
    end else if (capture) begin
      buf_valid_d = 1'b1;
      buf_d       = inst_rdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      pc1_q       <= RESET_PC;
      pc2_q       <= RESET_PC2;
    end else begin
      valid_q     <= valid_d;
      first_q     <= first_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      pc1_q       <= pc1_d;
      pc2_q       <= pc2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign inst_pair           = buf_valid_q ? buf_q : inst_rdata_i;
  assign adef                = valid_q & (pc1_q[1:0] != 2'b00);

  assign now_allowin_o       = load;
  assign now_to_next_valid_o = valid_q & !flush;
  assign to_preif_obus       = pc1_q;
  assign to_id_obus          = {adef, pc2_q, inst_pair[63:32], pc1_q, inst_pair[31:0]};

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage using a cycle-by-cycle vector table

module tb_if_stage;

  logic          clk;
  logic          rst_n;
  logic          pre_to_now_valid_i;
  logic [63:0]   pre_to_ibus;
  logic          now_allowin_o;
  logic [63:0]   inst_rdata_i;
  logic          next_allowin_i;
  logic          now_to_next_valid_o;
  logic          branch_flush_i;
  logic          excep_flush_i;
  logic [31:0]   to_preif_obus;
  logic [128:0]  to_id_obus;

  int total;
  int bad;

  if_stage dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pre_to_now_valid_i  (pre_to_now_valid_i),
    .pre_to_ibus         (pre_to_ibus),
    .now_allowin_o       (now_allowin_o),
    .inst_rdata_i        (inst_rdata_i),
    .next_allowin_i      (next_allowin_i),
    .now_to_next_valid_o (now_to_next_valid_o),
    .branch_flush_i      (branch_flush_i),
    .excep_flush_i       (excep_flush_i),
    .to_preif_obus       (to_preif_obus),
    .to_id_obus          (to_id_obus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          pv;
    logic [63:0]   pre;
    logic [63:0]   rd;
    logic          na;
    logic          bf;
    logic          ef;
    logic          nv;
    logic          aw;
    logic [31:0]   preif;
    logic [128:0]  obus;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  function automatic logic [128:0] mk(input logic a, input logic [31:0] p2, input logic [31:0] i2,
                                      input logic [31:0] p1, input logic [31:0] i1);
    return {a, p2, i2, p1, i1};
  endfunction

  function automatic vec_t v(input logic pv, input logic [63:0] pre, input logic [63:0] rd,
                             input logic na, input logic bf, input logic ef,
                             input logic nv, input logic aw, input logic [31:0] preif,
                             input logic [128:0] obus);
    vec_t r;
    r.pv = pv; r.pre = pre; r.rd = rd; r.na = na; r.bf = bf; r.ef = ef;
    r.nv = nv; r.aw = aw; r.preif = preif; r.obus = obus;
    return r;
  endfunction

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    pre_to_now_valid_i = r.pv;
    pre_to_ibus        = r.pre;
    inst_rdata_i       = r.rd;
    next_allowin_i     = r.na;
    branch_flush_i     = r.bf;
    excep_flush_i      = r.ef;
  endtask

  task automatic check_outs(input string tag, input logic nv, input logic aw,
                            input logic [31:0] preif, input logic [128:0] obus);
    chk({tag, " nv"},    {128'd0, now_to_next_valid_o}, {128'd0, nv});
    chk({tag, " aw"},    {128'd0, now_allowin_o},       {128'd0, aw});
    chk({tag, " preif"}, {97'd0, to_preif_obus},        {97'd0, preif});
    chk({tag, " obus"},  to_id_obus,                    obus);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Cycle-by-cycle trace; expected values are the outputs seen mid-cycle
    // with that row's inputs applied, before the closing rising edge.
    tbl[0]  = v(1, 64'h1C000004_1C000000, 64'h11112222_33334444, 1, 0, 0,
                0, 1, 32'h1BFFFFFC, mk(0, 32'h1C000000, 32'h11112222, 32'h1BFFFFFC, 32'h33334444));
    // first fetch hands off straight away
    tbl[1]  = v(0, 64'h1C00000C_1C000008, 64'hAAAABBBB_CCCCDDDD, 1, 0, 0,
                1, 1, 32'h1C000000, mk(0, 32'h1C000004, 32'hAAAABBBB, 32'h1C000000, 32'hCCCCDDDD));
    tbl[2]  = v(1, 64'h1C000014_1C000010, 64'h55556666_77778888, 1, 0, 0,
                0, 1, 32'h1C000008, mk(0, 32'h1C00000C, 32'h55556666, 32'h1C000008, 32'h77778888));
    // three-cycle stall, RAM output turns to garbage after the live cycle
    tbl[3]  = v(1, 64'h1C00001C_1C000018, 64'h12345678_9ABCDEF0, 0, 0, 0,
                1, 0, 32'h1C000010, mk(0, 32'h1C000014, 32'h12345678, 32'h1C000010, 32'h9ABCDEF0));
    tbl[4]  = v(1, 64'h1C00001C_1C000018, 64'hDEADBEEF_DEADBEEF, 0, 0, 0,
                1, 0, 32'h1C000010, mk(0, 32'h1C000014, 32'h12345678, 32'h1C000010, 32'h9ABCDEF0));
    tbl[5]  = v(1, 64'h1C00001C_1C000018, 64'h0BADF00D_0BADF00D, 0, 0, 0,
                1, 0, 32'h1C000010, mk(0, 32'h1C000014, 32'h12345678, 32'h1C000010, 32'h9ABCDEF0));
    tbl[6]  = v(1, 64'h1C00001C_1C000018, 64'hFEEDFACE_FEEDFACE, 1, 0, 0,
                1, 1, 32'h1C000010, mk(0, 32'h1C000014, 32'h12345678, 32'h1C000010, 32'h9ABCDEF0));
    // buffer must be empty again: inst comes from RAM
    tbl[7]  = v(1, 64'h1C000104_1C000100, 64'hA5A5A5A5_5A5A5A5A, 0, 0, 0,
                1, 0, 32'h1C000018, mk(0, 32'h1C00001C, 32'hA5A5A5A5, 32'h1C000018, 32'h5A5A5A5A));
    // branch flush on a stalled, buffered packet
    tbl[8]  = v(1, 64'h1C000104_1C000100, 64'hFFFF0000_0000FFFF, 0, 1, 0,
                0, 1, 32'h1C000018, mk(0, 32'h1C00001C, 32'hA5A5A5A5, 32'h1C000018, 32'h5A5A5A5A));
    tbl[9]  = v(1, 64'h1C00010C_1C000108, 64'h01020304_05060708, 0, 0, 0,
                1, 0, 32'h1C000100, mk(0, 32'h1C000104, 32'h01020304, 32'h1C000100, 32'h05060708));
    // both flushes together
    tbl[10] = v(1, 64'h1C008004_1C008000, 64'h99999999_99999999, 0, 1, 1,
                0, 1, 32'h1C000100, mk(0, 32'h1C000104, 32'h01020304, 32'h1C000100, 32'h05060708));
    tbl[11] = v(1, 64'h1C000006_1C000002, 64'h13579BDF_2468ACE0, 1, 0, 0,
                1, 1, 32'h1C008000, mk(0, 32'h1C008004, 32'h13579BDF, 32'h1C008000, 32'h2468ACE0));
    // misaligned pc1 raises adef, then stalls
    tbl[12] = v(1, 64'h1C00000E_1C00000A, 64'hCAFEBABE_FACEFEED, 0, 0, 0,
                1, 0, 32'h1C000002, mk(1, 32'h1C000006, 32'hCAFEBABE, 32'h1C000002, 32'hFACEFEED));
    tbl[13] = v(1, 64'h1C00000E_1C00000A, 64'h00000000_00000000, 0, 0, 0,
                1, 0, 32'h1C000002, mk(1, 32'h1C000006, 32'hCAFEBABE, 32'h1C000002, 32'hFACEFEED));

    // Reset state
    rst_n = 1'b0;
    drive(v(0, 64'h0, 64'h11112222_33334444, 0, 0, 0, 0, 0, 32'h0, 129'h0));
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 1, 32'h1BFFFFFC,
               mk(0, 32'h1C000000, 32'h11112222, 32'h1BFFFFFC, 32'h33334444));
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check_outs($sformatf("row%0d", i), tbl[i].nv, tbl[i].aw, tbl[i].preif, tbl[i].obus);
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-stall: outputs drop immediately, before any clock edge
    inst_rdata_i = 64'h76543210_FEDCBA98;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("midstall_rst", 0, 1, 32'h1BFFFFFC,
               mk(0, 32'h1C000000, 32'h76543210, 32'h1BFFFFFC, 32'hFEDCBA98));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First load after release comes from pre_to_ibus; pc2 wraps to 0 silently
    drive(v(1, 64'h00000000_FFFFFFFC, 64'h31415926_27182818, 1, 0, 0, 0, 0, 32'h0, 129'h0));
    @(negedge clk);
    check_outs("post_rst_idle", 0, 1, 32'h1BFFFFFC,
               mk(0, 32'h1C000000, 32'h31415926, 32'h1BFFFFFC, 32'h27182818));
    @(posedge clk);
    #1;
    drive(v(0, 64'h00000008_00000004, 64'h31415926_27182818, 1, 0, 0, 0, 0, 32'h0, 129'h0));
    @(negedge clk);
    check_outs("wrap", 1, 1, 32'hFFFFFFFC,
               mk(0, 32'h00000000, 32'h31415926, 32'hFFFFFFFC, 32'h27182818));
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1BFF_FFFC; value held in the PC register at reset, so the upstream +4 yields 32'h1C00_0000 as the first fetch.
REQ-002 SHALL have parameter PC_W, default 32; PC width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port pre_to_now_valid_i  input  1  pre-fetch stage offers a PC pair this cycle.
REQ-006 SHALL have port pre_to_ibus  input  64  {pc2, pc1} from the pre-fetch stage; pc2 = pc1+4.
REQ-007 SHALL have port now_allowin_o  output  1  this stage accepts a new PC pair this cycle.
REQ-008 SHALL have port inst_rdata_i  input  64  {inst2, inst1} from the synchronous inst RAM; valid only in the first cycle after a PC pair is loaded.
REQ-009 SHALL have port next_allowin_i  input  1  decode stage accepts this cycle.
REQ-010 SHALL have port now_to_next_valid_o  output  1  fetch packet is valid toward decode.
REQ-011 SHALL have port branch_flush_i  input  1  taken branch resolved in decode; current content is wrong-path.
REQ-012 SHALL have port excep_flush_i  input  1  exception entry or ertn from CSR; current content is killed.
REQ-013 SHALL have port to_preif_obus  output  32  current PC register (pc1) fed back to pre-fetch.
REQ-014 SHALL have port to_id_obus  output  129  {adef, pc2, inst2, pc1, inst1} toward decode.

Function
REQ-015 SHALL hold state: valid_r, pc1_r, pc2_r, buf_valid_r, buf_r[63:0], first_r (RAM data live this cycle).
REQ-016 SHALL use ready_go = 1; now_allowin_o = !valid_r | next_allowin_i | branch_flush_i | excep_flush_i.
REQ-017 SHALL load {pc2_r, pc1_r} from pre_to_ibus and set valid_r <= pre_to_now_valid_i whenever now_allowin_o is 1; first_r <= pre_to_now_valid_i on load, else 0.
REQ-018 SHALL drive now_to_next_valid_o = valid_r & !branch_flush_i & !excep_flush_i (combinational kill, same cycle as flush).
REQ-019 SHALL on a flush cycle discard current content: buf_valid_r <= 0; new PC from pre-fetch (branch/exception target) loaded per REQ-017.
REQ-020 SHALL select fetched instructions as buf_valid_r ? buf_r : inst_rdata_i.
REQ-021 SHALL capture inst_rdata_i into buf_r and set buf_valid_r <= 1 when first_r & valid_r & !next_allowin_i & no flush (stalled in the data-live cycle).
REQ-022 SHALL clear buf_valid_r when the packet hands off (now_to_next_valid_o & next_allowin_i), on any load, or on any flush.
REQ-023 SHALL hold pc1_r, pc2_r, buf_r stable while valid_r & !next_allowin_i & no flush; stall of any length leaves to_id_obus unchanged.
REQ-024 SHALL set adef = valid_r & (pc1_r[1:0] != 2'b00); an adef packet still hands off normally, inst fields unspecified.
REQ-025 SHALL drive to_preif_obus = pc1_r at all times, including while invalid.
REQ-026 SHALL, on simultaneous branch_flush_i and excep_flush_i, behave as excep_flush_i (identical effect here; priority resolved upstream).
REQ-027 SHALL perform PC arithmetic modulo 2^PC_W; pc2 = 32'hFFFF_FFFC+4 wraps to 0 without flagging.
REQ-028 SHALL have zero-cycle latency from state to outputs (outputs purely from registers, inst_rdata_i and flush/allowin inputs).

Reset
REQ-029 SHALL on rst_n low, asynchronously: valid_r=0, first_r=0, buf_valid_r=0, buf_r=0, pc1_r=RESET_PC, pc2_r=RESET_PC+4.
REQ-030 SHALL drive during reset: now_to_next_valid_o=0, now_allowin_o=1, to_preif_obus=32'h1BFF_FFFC.
REQ-031 SHALL, if reset asserts mid-stall, drop the buffered packet; first load after release takes pc1 from pre_to_ibus.

Verification
REQ-032 Release reset, pre valid with {0x1C000004,0x1C000000}, rdata=0xAAAA_BBBB_CCCC_DDDD, next_allowin=1 -> next cycle valid out, to_id_obus pc1=0x1C000000, inst1=0xCCCCDDDD, adef=0.
REQ-033 Load then next_allowin=0 for 3 cycles, rdata changes to garbage after cycle 1 -> to_id_obus keeps original inst pair; hands off when next_allowin=1; buf_valid clears.
REQ-034 Stalled valid packet + branch_flush_i with pre PC 0x1C000100 -> now_to_next_valid_o=0 that cycle, next cycle pc1=0x1C000100, buffer empty.
REQ-035 excep_flush_i and branch_flush_i same cycle, pre PC 0x1C008000 -> identical to excep-only: pc1=0x1C008000, no stale handoff.
REQ-036 Load pc1=0x1C000002 -> adef=1 with valid out; rst_n low mid-stall -> outputs immediately at reset values of REQ-029/030.
